mult_share_arb: RTL and testbench

- Shares one 5x5 pipelined shift-add multiplier (2-cycle internal latency, active-low async reset) between N_REQ requesters.
- Picks one request per cycle by round-robin and registers the chosen operands into the multiplier.
- Carries a requester tag alongside each operation through the multiplier latency, then returns the product with that tag.
- Sits between the lab datapath clients and the single shared multiplier instance.

---
 rtl/mult_share_pkg.sv | 14 +
 rtl/rr_arb.sv | 48 ++++
 rtl/mult_share_arb.sv | 103 ++++++++++
 tb/tb_mult_share_arb.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// Shared constants and the tag type for the multiplier-sharing arbiter.
package mult_share_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned OP_W    = 5;
    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned ID_W    = $clog2(NUM_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, pointer holds the last granted index.
module rr_arb #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_id
);

    logic [IW-1:0] ptr_q, ptr_d;
    int unsigned   idx;

    // Search starts one past the last winner and wraps modulo N.
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = (32'(ptr_q) + i) % N;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_id    = IW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid) begin
            ptr_d = gnt_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= IW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// Shares one pipelined multiplier among N_REQ requesters and returns tagged products.
// Optional counters enabled by defining MULT_SHARE_ARB_PERF_EN.
module mult_share_arb
    import mult_share_pkg::*;
#(
    parameter int unsigned N_REQ = NUM_REQ
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*OP_W-1:0] x_in,
    input  logic [N_REQ*OP_W-1:0] y_in,
    output logic [N_REQ-1:0]      gnt,
    output logic [OP_W-1:0]       mul_x,
    output logic [OP_W-1:0]       mul_y,
    output logic                  mul_rst_n,
    input  logic [2*OP_W-1:0]     mul_res,
`ifdef MULT_SHARE_ARB_PERF_EN
    output logic [15:0]           busy_cnt,
    output logic [15:0]           conflict_cnt,
`endif
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [2*OP_W-1:0]     rsp_data
);

    logic            gnt_valid;
    logic [ID_W-1:0] gnt_id;
    logic [OP_W-1:0] x_sel, y_sel;
    logic [OP_W-1:0] mul_x_q, mul_y_q;
    tag_t            tag_q [MUL_LAT+1];

    rr_arb #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_rr_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Zero operands when idle so the multiplier output settles to 0.
    always_comb begin
        x_sel = '0;
        y_sel = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (gnt[i]) begin
                x_sel = x_in[i*OP_W +: OP_W];
                y_sel = y_in[i*OP_W +: OP_W];
            end
        end
    end

    // The multiplier has no enable, so the tag chain never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_x_q <= '0;
            mul_y_q <= '0;
            for (int i = 0; i <= int'(MUL_LAT); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            mul_x_q  <= x_sel;
            mul_y_q  <= y_sel;
            tag_q[0] <= '{valid: gnt_valid, id: gnt_id};
            for (int i = 1; i <= int'(MUL_LAT); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;
    assign mul_rst_n = ~rst;
    assign rsp_valid = tag_q[MUL_LAT].valid;
    assign rsp_id    = tag_q[MUL_LAT].id;
    assign rsp_data  = mul_res;

`ifdef MULT_SHARE_ARB_PERF_EN
    logic [15:0] busy_q, conflict_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            conflict_q <= '0;
        end else begin
            if (gnt_valid && busy_q != 16'hFFFF) begin
                busy_q <= busy_q + 16'd1;
            end
            if ($countones(req) > 1 && conflict_q != 16'hFFFF) begin
                conflict_q <= conflict_q + 16'd1;
            end
        end
    end

    assign busy_cnt     = busy_q;
    assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with a behavioural 2-stage 5x5 multiplier alongside.
module tb_mult_share_arb;
    import mult_share_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [19:0] x_in = '0;
    logic [19:0] y_in = '0;
    logic [3:0]  gnt;
    logic [4:0]  mul_x, mul_y;
    logic        mul_rst_n;
    logic [9:0]  mul_res;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [9:0]  rsp_data;
`ifdef MULT_SHARE_ARB_PERF_EN
    logic [15:0] busy_cnt, conflict_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mult_share_arb #(.N_REQ(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .x_in         (x_in),
        .y_in         (y_in),
        .gnt          (gnt),
        .mul_x        (mul_x),
        .mul_y        (mul_y),
        .mul_rst_n    (mul_rst_n),
        .mul_res      (mul_res),
`ifdef MULT_SHARE_ARB_PERF_EN
        .busy_cnt     (busy_cnt),
        .conflict_cnt (conflict_cnt),
`endif
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data)
    );

    // Shared multiplier: two register stages, active-low async reset.
    logic [9:0] p1, p2;
    always_ff @(posedge clk or negedge mul_rst_n) begin
        if (!mul_rst_n) begin
            p1 <= '0;
            p2 <= '0;
        end else begin
            p1 <= 10'(mul_x) * 10'(mul_y);
            p2 <= p1;
        end
    end
    assign mul_res = p2;

    function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Drive one cycle (entered at posedge+1), check outputs, advance to the next posedge+1.
    task automatic cyc(input string tag, input logic [3:0] r, input logic [19:0] xv,
                       input logic [19:0] yv, input logic [3:0] eg, input logic erv,
                       input logic [1:0] eid, input logic [9:0] ed);
        req  = r;
        x_in = xv;
        y_in = yv;
        #1;
        chk({tag, " gnt"}, 16'(gnt), 16'(eg));
        chk({tag, " rsp_valid"}, 16'(rsp_valid), 16'(erv));
        if (erv) begin
            chk({tag, " rsp_id"}, 16'(rsp_id), 16'(eid));
            chk({tag, " rsp_data"}, 16'(rsp_data), 16'(ed));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        req = '0;
        #1;
        chk({tag, " rst gnt"}, 16'(gnt), 16'd0);
        chk({tag, " rst mul_x"}, 16'(mul_x), 16'd0);
        chk({tag, " rst mul_y"}, 16'(mul_y), 16'd0);
        chk({tag, " rst rsp_valid"}, 16'(rsp_valid), 16'd0);
        chk({tag, " rst rsp_id"}, 16'(rsp_id), 16'd0);
        chk({tag, " rst rsp_data"}, 16'(rsp_data), 16'd0);
        chk({tag, " rst mul_rst_n"}, 16'(mul_rst_n), 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Single request, response three cycles later.
        do_reset("s1");
        cyc("s1 c0", 4'b0001, pk(3, 0, 0, 0), pk(7, 0, 0, 0), 4'b0001, 0, 0, 0);
        cyc("s1 c1", 4'b0000, '0, '0, 4'b0000, 0, 0, 0);
        cyc("s1 c2", 4'b0000, '0, '0, 4'b0000, 0, 0, 0);
        cyc("s1 c3", 4'b0000, '0, '0, 4'b0000, 1, 0, 10'd21);
        cyc("s1 c4", 4'b0000, '0, '0, 4'b0000, 0, 0, 0);
        cyc("s1 c5", 4'b0000, '0, '0, 4'b0000, 0, 0, 0);

        // All four requesting: rotation 0,1,2,3 and products 31*(id+1).
        do_reset("s2");
        for (int c = 0; c < 11; c++) begin
            cyc($sformatf("s2 c%0d", c), (c < 8) ? 4'hF : 4'h0,
                pk(1, 2, 3, 4), pk(31, 31, 31, 31),
                (c < 8) ? 4'(1 << (c % 4)) : 4'h0,
                c >= 3, 2'((c + 1) % 4), 10'(31 * (((c + 1) % 4) + 1)));
        end
`ifdef MULT_SHARE_ARB_PERF_EN
        chk("s2 busy_cnt", busy_cnt, 16'd8);
        chk("s2 conflict_cnt", conflict_cnt, 16'd8);
`endif

        // Back-to-back from requester 0, including max product and zero operand.
        do_reset("s3");
        cyc("s3 c0", 4'b0001, pk(31, 0, 0, 0), pk(31, 0, 0, 0), 4'b0001, 0, 0, 0);
        cyc("s3 c1", 4'b0001, pk(0, 0, 0, 0), pk(5, 0, 0, 0), 4'b0001, 0, 0, 0);
        cyc("s3 c2", 4'b0001, pk(1, 0, 0, 0), pk(1, 0, 0, 0), 4'b0001, 0, 0, 0);
        cyc("s3 c3", 4'b0001, pk(16, 0, 0, 0), pk(2, 0, 0, 0), 4'b0001, 1, 0, 10'd961);
        cyc("s3 c4", 4'b0000, '0, '0, 4'b0000, 1, 0, 10'd0);
        cyc("s3 c5", 4'b0000, '0, '0, 4'b0000, 1, 0, 10'd1);
        cyc("s3 c6", 4'b0000, '0, '0, 4'b0000, 1, 0, 10'd32);
        cyc("s3 c7", 4'b0000, '0, '0, 4'b0000, 0, 0, 0);

        // Reset mid-flight drops both in-flight ops and returns the pointer to 3.
        do_reset("s4");
        cyc("s4 c0", 4'b0001, pk(5, 0, 0, 0), pk(5, 0, 0, 0), 4'b0001, 0, 0, 0);
        cyc("s4 c1", 4'b0010, pk(0, 6, 0, 0), pk(0, 6, 0, 0), 4'b0010, 0, 0, 0);
        rst = 1'b1;
        req = '0;
        #1;
        chk("s4 c2 rsp_valid", 16'(rsp_valid), 16'd0);
        chk("s4 c2 gnt", 16'(gnt), 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("s4 c3", 4'b1001, pk(2, 0, 0, 9), pk(3, 0, 0, 9), 4'b0001, 0, 0, 0);
        cyc("s4 c4", 4'b0000, '0, '0, 4'b0000, 0, 0, 0);
        cyc("s4 c5", 4'b0000, '0, '0, 4'b0000, 0, 0, 0);
        cyc("s4 c6", 4'b0000, '0, '0, 4'b0000, 1, 0, 10'd6);
        cyc("s4 c7", 4'b0000, '0, '0, 4'b0000, 0, 0, 0);

        // Pointer fairness: after grant to 2, order is 3,0,1,2.
        do_reset("s5");
        cyc("s5 c0", 4'b0100, pk(0, 0, 4, 0), pk(0, 0, 4, 0), 4'b0100, 0, 0, 0);
        cyc("s5 c1", 4'b0101, pk(2, 0, 4, 0), pk(2, 0, 4, 0), 4'b0001, 0, 0, 0);
        cyc("s5 c2", 4'b0101, pk(2, 0, 4, 0), pk(2, 0, 4, 0), 4'b0100, 0, 0, 0);
        cyc("s5 c3", 4'b1000, pk(0, 0, 0, 3), pk(0, 0, 0, 3), 4'b1000, 1, 2, 10'd16);
        cyc("s5 c4", 4'b0000, '0, '0, 4'b0000, 1, 0, 10'd4);
        cyc("s5 c5", 4'b0000, '0, '0, 4'b0000, 1, 2, 10'd16);
        cyc("s5 c6", 4'b0000, '0, '0, 4'b0000, 1, 3, 10'd9);
        cyc("s5 c7", 4'b0000, '0, '0, 4'b0000, 0, 0, 0);

`ifdef MULT_SHARE_ARB_PERF_EN
        // Busy counter saturates after more than 65535 grant cycles.
        req = 4'b0010;
        repeat (70000) @(posedge clk);
        #1;
        req = '0;
        chk("perf busy_cnt sat", busy_cnt, 16'hFFFF);
        chk("perf conflict_cnt hold", conflict_cnt, 16'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
